// File: rtl/alu_trace_checker_pkg.sv
// Shared types and default sizes for the ALU trace checker.
// Latency: n/a.  Backpressure: n/a.
package alu_trace_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 64;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/alu_trace_checker_if.sv
// Load / run-control / sample / status bundle between a trace source and the checker.
// Latency: n/a.  Backpressure: none, the sample stream is throttled only by sample_valid.
interface alu_trace_checker_if
    import alu_trace_checker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = $clog2(DEF_DEPTH),
    parameter int CNT_W = DEF_CNT_W
);
    logic             load_we;
    logic [AW-1:0]    load_addr;
    logic [WIDTH+1:0] load_data;
    logic             start;
    logic [AW:0]      num_vec;
    logic             sample_valid;
    logic [WIDTH-1:0] dut_f;
    logic             dut_zf;
    logic             dut_of;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic             first_err_valid;
    logic [AW-1:0]    first_err_idx;

    modport master (
        output load_we, load_addr, load_data, start, num_vec,
               sample_valid, dut_f, dut_zf, dut_of,
        input  busy, done, pass, err_count, first_err_valid, first_err_idx
    );

    modport slave (
        input  load_we, load_addr, load_data, start, num_vec,
               sample_valid, dut_f, dut_zf, dut_of,
        output busy, done, pass, err_count, first_err_valid, first_err_idx
    );
endinterface

// File: rtl/alu_trace_checker_exp_ram.sv
// Expected-vector store: synchronous write, combinational read, not reset.
// Latency: write visible the cycle after we; read is same-cycle.  Backpressure: none.
module alu_trace_checker_exp_ram #(
    parameter int DW    = 34,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/alu_trace_checker.sv
// Compares a stream of ALU results against a preloaded expected-vector table.
// Latency: sample to err_count/first_err update 1 cycle; done/pass the cycle after the last compare.
// Backpressure: none; the checker consumes every sample_valid beat, idle cycles simply stall it.
module alu_trace_checker
    import alu_trace_checker_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int SKIP     = 0,
    parameter int FLAG_CHK = 1,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_trace_checker_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = WIDTH + 2;
    localparam int SW = (SKIP < 1) ? 1 : $clog2(SKIP + 1);

    state_t           state, state_d;
    logic [AW:0]      idx, idx_d;
    logic [AW:0]      tgt, tgt_d;
    logic [SW-1:0]    skip_cnt, skip_cnt_d;
    logic [CNT_W-1:0] err, err_d;
    logic             fev, fev_d;
    logic [AW-1:0]    fei, fei_d;
    logic             pass_q, pass_d;
    logic [DW-1:0]    exp_dat;
    logic [AW:0]      nv_clamp;
    logic             mism;
    logic             warm;
    logic             ram_we;

    assign ram_we = bus.load_we && (state != RUN);

    alu_trace_checker_exp_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_exp_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (bus.load_addr),
        .wdata (bus.load_data),
        .raddr (idx[AW-1:0]),
        .rdata (exp_dat)
    );

    assign nv_clamp = (bus.num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.num_vec;

    // Expected word layout is {OF, ZF, F}.
    assign mism = (FLAG_CHK != 0) ? ({bus.dut_of, bus.dut_zf, bus.dut_f} != exp_dat)
                                  : (bus.dut_f != exp_dat[WIDTH-1:0]);

    assign warm = (SKIP != 0) && (skip_cnt != SW'(SKIP));

    always_comb begin
        state_d    = state;
        idx_d      = idx;
        tgt_d      = tgt;
        skip_cnt_d = skip_cnt;
        err_d      = err;
        fev_d      = fev;
        fei_d      = fei;
        pass_d     = pass_q;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    idx_d      = '0;
                    skip_cnt_d = '0;
                    err_d      = '0;
                    fev_d      = 1'b0;
                    fei_d      = '0;
                    tgt_d      = nv_clamp;
                    if (nv_clamp == '0) begin
                        state_d = DONE;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        pass_d  = 1'b0;
                    end
                end
            end
            RUN: begin
                if (bus.sample_valid) begin
                    if (warm) begin
                        skip_cnt_d = skip_cnt + 1'b1;
                    end else begin
                        idx_d = idx + 1'b1;
                        if (mism) begin
                            if (err != '1) begin
                                err_d = err + 1'b1;
                            end
                            if (!fev) begin
                                fev_d = 1'b1;
                                fei_d = idx[AW-1:0];
                            end
                        end
                        // pass is judged on the count including this final compare.
                        if (idx == tgt - 1'b1) begin
                            state_d = DONE;
                            pass_d  = (err_d == '0);
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pass_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            idx      <= '0;
            tgt      <= '0;
            skip_cnt <= '0;
            err      <= '0;
            fev      <= 1'b0;
            fei      <= '0;
            pass_q   <= 1'b0;
        end else begin
            state    <= state_d;
            idx      <= idx_d;
            tgt      <= tgt_d;
            skip_cnt <= skip_cnt_d;
            err      <= err_d;
            fev      <= fev_d;
            fei      <= fei_d;
            pass_q   <= pass_d;
        end
    end

    assign bus.busy            = (state == RUN);
    assign bus.done            = (state == DONE);
    assign bus.pass            = pass_q;
    assign bus.err_count       = err;
    assign bus.first_err_valid = fev;
    assign bus.first_err_idx   = fei;
endmodule

// File: tb/tb_alu_trace_checker.sv
// Directed bench for alu_trace_checker across four parameter sets sharing one stimulus bus.
module tb_alu_trace_checker;
    logic        clk;
    logic        rst;
    logic [3:0]  we_s, st_s, sv_s;
    logic [6:0]  la_s;
    logic [33:0] ld_s;
    logic [6:0]  nv_s;
    logic [31:0] f_s;
    logic        zf_s, of_s;
    int          checks;
    int          errors;

    // 0: defaults, 1: FLAG_CHK=0, 2: SKIP=2, 3: DEPTH=8 CNT_W=2
    alu_trace_checker_if #(.WIDTH(32), .AW(6), .CNT_W(8)) if_def ();
    alu_trace_checker_if #(.WIDTH(32), .AW(6), .CNT_W(8)) if_nf ();
    alu_trace_checker_if #(.WIDTH(32), .AW(6), .CNT_W(8)) if_skp ();
    alu_trace_checker_if #(.WIDTH(32), .AW(3), .CNT_W(2)) if_sat ();

    assign if_def.load_we = we_s[0];  assign if_def.start = st_s[0];  assign if_def.sample_valid = sv_s[0];
    assign if_nf.load_we  = we_s[1];  assign if_nf.start  = st_s[1];  assign if_nf.sample_valid  = sv_s[1];
    assign if_skp.load_we = we_s[2];  assign if_skp.start = st_s[2];  assign if_skp.sample_valid = sv_s[2];
    assign if_sat.load_we = we_s[3];  assign if_sat.start = st_s[3];  assign if_sat.sample_valid = sv_s[3];

    assign if_def.load_addr = la_s[5:0]; assign if_def.load_data = ld_s; assign if_def.num_vec = nv_s;
    assign if_nf.load_addr  = la_s[5:0]; assign if_nf.load_data  = ld_s; assign if_nf.num_vec  = nv_s;
    assign if_skp.load_addr = la_s[5:0]; assign if_skp.load_data = ld_s; assign if_skp.num_vec = nv_s;
    assign if_sat.load_addr = la_s[2:0]; assign if_sat.load_data = ld_s; assign if_sat.num_vec = nv_s[3:0];

    assign if_def.dut_f = f_s; assign if_def.dut_zf = zf_s; assign if_def.dut_of = of_s;
    assign if_nf.dut_f  = f_s; assign if_nf.dut_zf  = zf_s; assign if_nf.dut_of  = of_s;
    assign if_skp.dut_f = f_s; assign if_skp.dut_zf = zf_s; assign if_skp.dut_of = of_s;
    assign if_sat.dut_f = f_s; assign if_sat.dut_zf = zf_s; assign if_sat.dut_of = of_s;

    alu_trace_checker u_def (.clk(clk), .rst(rst), .bus(if_def));
    alu_trace_checker #(.FLAG_CHK(0)) u_nf (.clk(clk), .rst(rst), .bus(if_nf));
    alu_trace_checker #(.SKIP(2)) u_skp (.clk(clk), .rst(rst), .bus(if_skp));
    alu_trace_checker #(.DEPTH(8), .CNT_W(2)) u_sat (.clk(clk), .rst(rst), .bus(if_sat));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load(input int sel, input int addr, input logic [33:0] data);
        la_s = 7'(addr);
        ld_s = data;
        we_s[sel] = 1'b1;
        @(posedge clk); #1;
        we_s[sel] = 1'b0;
    endtask

    task automatic run_start(input int sel, input int n);
        nv_s = 7'(n);
        st_s[sel] = 1'b1;
        @(posedge clk); #1;
        st_s[sel] = 1'b0;
    endtask

    task automatic sample(input int sel, input logic [31:0] f, input logic zf, input logic of_);
        f_s  = f;
        zf_s = zf;
        of_s = of_;
        sv_s[sel] = 1'b1;
        @(posedge clk); #1;
        sv_s[sel] = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        we_s = '0; st_s = '0; sv_s = '0;
        la_s = '0; ld_s = '0; nv_s = '0; f_s = '0; zf_s = 1'b0; of_s = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", if_def.busy, 0);
        check("rst_done", if_def.done, 0);
        check("rst_pass", if_def.pass, 0);
        check("rst_err", if_def.err_count, 0);
        check("rst_fev", if_def.first_err_valid, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) load(0, i, 34'(i + 1));
        for (int i = 0; i < 4; i++) load(2, i, 34'(i + 1));
        for (int i = 0; i < 8; i++) load(3, i, 34'(i + 16));

        // all match, with an ignored start and idle cycles mid-run
        run_start(0, 4);
        check("m_busy", if_def.busy, 1);
        check("m_done0", if_def.done, 0);
        sample(0, 32'd1, 1'b0, 1'b0);
        run_start(0, 0);
        check("busy_start_ign", if_def.busy, 1);
        check("busy_start_nodone", if_def.done, 0);
        sample(0, 32'd2, 1'b0, 1'b0);
        @(posedge clk); #1;
        sample(0, 32'd3, 1'b0, 1'b0);
        check("m_done_early", if_def.done, 0);
        sample(0, 32'd4, 1'b0, 1'b0);
        check("m_done", if_def.done, 1);
        check("m_pass", if_def.pass, 1);
        check("m_err", if_def.err_count, 0);
        check("m_busy_end", if_def.busy, 0);

        // one mismatch at index 2
        run_start(0, 4);
        check("mm_pass_clr", if_def.pass, 0);
        check("mm_done_clr", if_def.done, 0);
        sample(0, 32'd1, 1'b0, 1'b0);
        sample(0, 32'd2, 1'b0, 1'b0);
        sample(0, 32'h99, 1'b0, 1'b0);
        check("mm_err_lat", if_def.err_count, 1);
        sample(0, 32'd4, 1'b0, 1'b0);
        check("mm_done", if_def.done, 1);
        check("mm_err", if_def.err_count, 1);
        check("mm_fev", if_def.first_err_valid, 1);
        check("mm_fei", if_def.first_err_idx, 2);
        check("mm_pass", if_def.pass, 0);
        sample(0, 32'h77, 1'b0, 1'b0);
        check("done_sample_ign", if_def.err_count, 1);

        // zero-length run from DONE with errors
        run_start(0, 0);
        check("z_done", if_def.done, 1);
        check("z_pass", if_def.pass, 1);
        check("z_err", if_def.err_count, 0);
        check("z_fev", if_def.first_err_valid, 0);

        // memory write while busy must not land
        run_start(0, 4);
        sample(0, 32'd1, 1'b0, 1'b0);
        load(0, 1, 34'h77);
        sample(0, 32'd2, 1'b0, 1'b0);
        sample(0, 32'd3, 1'b0, 1'b0);
        sample(0, 32'd4, 1'b0, 1'b0);
        check("ld_busy_pass", if_def.pass, 1);
        check("ld_busy_err", if_def.err_count, 0);

        // reset mid-run, then rerun on retained memory
        run_start(0, 4);
        sample(0, 32'd1, 1'b0, 1'b0);
        sample(0, 32'h55, 1'b0, 1'b0);
        check("pre_rst_fei", if_def.first_err_idx, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", if_def.busy, 0);
        check("mid_rst_done", if_def.done, 0);
        check("mid_rst_pass", if_def.pass, 0);
        check("mid_rst_err", if_def.err_count, 0);
        check("mid_rst_fev", if_def.first_err_valid, 0);
        check("mid_rst_fei", if_def.first_err_idx, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_start(0, 4);
        for (int i = 1; i <= 4; i++) sample(0, 32'(i), 1'b0, 1'b0);
        check("rerun_done", if_def.done, 1);
        check("rerun_pass", if_def.pass, 1);

        // flag-only difference: caught with FLAG_CHK=1, ignored with FLAG_CHK=0
        load(0, 0, 34'h1_0000_0005);
        load(1, 0, 34'h1_0000_0005);
        run_start(0, 1);
        sample(0, 32'd5, 1'b0, 1'b0);
        check("flg_err", if_def.err_count, 1);
        check("flg_pass", if_def.pass, 0);
        run_start(1, 1);
        sample(1, 32'd5, 1'b0, 1'b0);
        check("nf_done", if_nf.done, 1);
        check("nf_pass", if_nf.pass, 1);
        check("nf_err", if_nf.err_count, 0);

        // warm-up samples discarded
        run_start(2, 4);
        sample(2, 32'hdead, 1'b1, 1'b1);
        sample(2, 32'hbeef, 1'b0, 1'b1);
        for (int i = 1; i <= 3; i++) sample(2, 32'(i), 1'b0, 1'b0);
        check("skp_done_early", if_skp.done, 0);
        check("skp_busy", if_skp.busy, 1);
        sample(2, 32'd4, 1'b0, 1'b0);
        check("skp_done", if_skp.done, 1);
        check("skp_pass", if_skp.pass, 1);
        check("skp_err", if_skp.err_count, 0);

        // num_vec above DEPTH clamps to 8; counter saturates at 3
        run_start(3, 15);
        for (int i = 0; i < 7; i++) sample(3, 32'd0, 1'b0, 1'b0);
        check("sat_done_early", if_sat.done, 0);
        check("sat_err_mid", if_sat.err_count, 3);
        sample(3, 32'd0, 1'b0, 1'b0);
        check("sat_done", if_sat.done, 1);
        check("sat_err", if_sat.err_count, 3);
        check("sat_fev", if_sat.first_err_valid, 1);
        check("sat_fei", if_sat.first_err_idx, 0);
        check("sat_pass", if_sat.pass, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_trace_checker.md
ALU_TRACE_CHECKER -- requirements
Module: alu_trace_checker

Interface
REQ-001 Parameter WIDTH, default 32, result bus width.
REQ-002 Parameter DEPTH, default 64, number of expected-vector entries; AW = clog2(DEPTH).
REQ-003 Parameter SKIP, default 0, number of warm-up samples discarded after start.
REQ-004 Parameter FLAG_CHK, default 1; 1 = compare ZF/OF and F, 0 = compare F only.
REQ-005 Parameter CNT_W, default 8, error counter width.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-008 load_we  input  1  write strobe for expected-vector memory.
REQ-009 load_addr  input  AW  write address.
REQ-010 load_data  input  WIDTH+2  expected {OF, ZF, F}.
REQ-011 start  input  1  one-cycle pulse, begin a check run.
REQ-012 num_vec  input  AW+1  vectors to check, sampled on start.
REQ-013 sample_valid  input  1  DUT outputs valid this cycle.
REQ-014 dut_f  input  WIDTH  DUT ALU_F.
REQ-015 dut_zf / dut_of  input  1 each  DUT flags.
REQ-016 busy  output  1  run in progress.
REQ-017 done  output  1  run complete, held until next start.
REQ-018 pass  output  1  done and zero errors.
REQ-019 err_count  output  CNT_W  mismatch count, saturating.
REQ-020 first_err_valid / first_err_idx  output  1 / AW  first mismatching vector index.

Function
REQ-021 FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after vector num_vec-1 compared; DONE->RUN on start.
REQ-022 start with num_vec=0 SHALL go IDLE/DONE->DONE next cycle with pass=1, err_count=0.
REQ-023 On accepted start: idx, skip_cnt, err_count, first_err_valid cleared; done/pass deasserted the next cycle.
REQ-024 start while busy SHALL be ignored; num_vec > DEPTH SHALL be clamped to DEPTH.
REQ-025 In RUN, each sample_valid with skip_cnt<SKIP SHALL only increment skip_cnt.
REQ-026 Otherwise sample compared against mem[idx] (F bits only when FLAG_CHK=0); idx increments by one; latency sample->err_count update = 1 cycle.
REQ-027 Mismatch SHALL increment err_count, saturating at 2^CNT_W-1; first mismatch captures idx into first_err_idx and sets first_err_valid.
REQ-028 sample_valid low SHALL stall comparison with no state change.
REQ-029 load_we while busy SHALL be ignored; in IDLE/DONE writes memory at rising edge.
REQ-030 done asserted the cycle after the last compare; pass = done AND err_count==0, registered.
REQ-031 sample_valid in IDLE/DONE SHALL be ignored.

Reset
REQ-032 rst low SHALL immediately force IDLE, busy=0, done=0, pass=0, err_count=0, first_err_valid=0, first_err_idx=0, including mid-run.
REQ-033 Expected-vector memory contents SHALL NOT be cleared by reset.

Structure
REQ-034 Shared package holds state enum (IDLE/RUN/DONE) and default WIDTH/DEPTH/CNT_W constants.
REQ-035 One sub-module exp_ram: synchronous write, combinational read, WIDTH+2 x DEPTH.

Verification
REQ-036 Load 4 vectors F=1,2,3,4 flags 0; start num_vec=4; feed matching samples -> done after 4th, pass=1, err_count=0.
REQ-037 Same load, sample 2 F=0x99 -> err_count=1, first_err_idx=2, pass=0.
REQ-038 FLAG_CHK=0, expected ZF=1, dut_zf=0, F matches -> pass=1; FLAG_CHK=1 -> err_count=1.
REQ-039 SKIP=2, 6 samples, first 2 garbage, rest match 4 vectors -> pass=1.
REQ-040 CNT_W=2, 8 mismatching vectors -> err_count saturates at 3, first_err_idx=0.
REQ-041 rst low during RUN after 2 samples -> all outputs 0 immediately; restart with same vectors -> pass=1.
